// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared constants and state encoding for dmem_arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam int M0            = 0;
  localparam int M1            = 1;
  localparam int NPORTS        = 2;
  localparam int DEFAULT_DEPTH = 1024;
  localparam int CNT_W         = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN1 = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_if : one requester port of the data-memory arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_wait_counter : saturating count of consecutive m1 denials         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic inc_i,
  input  wire logic clr_i,
  output logic      at_max_o
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != c_max)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == c_max);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : m0-priority data-memory arbiter with m1 anti-starve,  |
// | m1 burst lock and out-of-range rejection.              Rev 1.0       |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int MAX_WAIT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  dmem_arbiter_if.slave          m0,
  dmem_arbiter_if.slave          m1,
  input  wire logic              m1_lock_i,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  wire logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  state_e                          state_q;
  state_e                          state_d;
  logic [NPORTS-1:0]               w_req;
  logic [NPORTS-1:0]               w_we;
  logic [NPORTS-1:0]               w_gnt;
  logic [NPORTS-1:0]               w_ok;
  logic [NPORTS-1:0][ADDR_W-1:0]   w_addr;
  logic [NPORTS-1:0][DATA_W-1:0]   w_wdata;
  logic [NPORTS-1:0]               w_rvalid;
  logic [NPORTS-1:0]               w_err;
  logic [NPORTS-1:0][DATA_W-1:0]   w_rdata;
  logic                            w_at_max;
  logic                            w_any;
  logic                            w_sel;

  assign w_req[M0]   = m0.req;
  assign w_req[M1]   = m1.req;
  assign w_we[M0]    = m0.we;
  assign w_we[M1]    = m1.we;
  assign w_addr[M0]  = m0.addr;
  assign w_addr[M1]  = m1.addr;
  assign w_wdata[M0] = m0.wdata;
  assign w_wdata[M1] = m1.wdata;

  rr_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (w_req[M1] & ~w_gnt[M1]),
    .clr_i    (w_gnt[M1] | ~w_req[M1]),
    .at_max_o (w_at_max)
  );

  // Grants are suppressed while reset is asserted so the memory bus goes quiet at once.
  always_comb begin
    state_d = state_q;
    w_gnt   = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (w_req[M1] && w_at_max) begin
            w_gnt[M1] = 1'b1;
          end else if (w_req[M0]) begin
            w_gnt[M0] = 1'b1;
          end else if (w_req[M1]) begin
            w_gnt[M1] = 1'b1;
          end
          if (w_gnt[M1] && m1_lock_i) begin
            state_d = OWN1;
          end
        end
        OWN1: begin
          w_gnt[M1] = w_req[M1];
          if (!w_req[M1] || !m1_lock_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_any       = |w_gnt;
  assign w_sel       = w_gnt[M1];
  assign mem_addr_o  = w_any ? w_addr[w_sel]  : '0;
  assign mem_wdata_o = w_any ? w_wdata[w_sel] : '0;
  assign mem_write_o = w_any &  w_we[w_sel] & w_ok[w_sel];
  assign mem_read_o  = w_any & ~w_we[w_sel] & w_ok[w_sel];

  for (genvar i = 0; i < NPORTS; i++) begin : g_ret
    logic              rvalid_q;
    logic              rvalid_d;
    logic              err_q;
    logic              err_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    assign w_ok[i] = ({1'b0, w_addr[i]} < c_depth);

    always_comb begin
      rvalid_d = w_gnt[i] & (~w_we[i] | ~w_ok[i]);
      err_d    = w_gnt[i] & ~w_ok[i];
      rdata_d  = rdata_q;
      if (w_gnt[i] && !w_ok[i]) begin
        rdata_d = '0;
      end else if (w_gnt[i] && !w_we[i]) begin
        rdata_d = mem_rdata_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        err_q    <= err_d;
        rdata_q  <= rdata_d;
      end
    end

    assign w_rvalid[i] = rvalid_q;
    assign w_err[i]    = err_q;
    assign w_rdata[i]  = rdata_q;
  end

  assign m0.gnt    = w_gnt[M0];
  assign m1.gnt    = w_gnt[M1];
  assign m0.rvalid = w_rvalid[M0];
  assign m1.rvalid = w_rvalid[M1];
  assign m0.err    = w_err[M0];
  assign m1.err    = w_err[M1];
  assign m0.rdata  = w_rdata[M0];
  assign m1.rdata  = w_rdata[M1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed table-driven bench for dmem_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  localparam logic [31:0] B = 32'hB000_0000;
  localparam logic [31:0] P = 32'h1000_0000;

  typedef struct {
    bit m0r; bit m0w; logic [31:0] m0a; logic [31:0] m0d;
    bit m1r; bit m1w; logic [31:0] m1a; logic [31:0] m1d; bit m1l;
    bit g0;  bit g1;  bit rd; bit wr; logic [31:0] ad;
    bit v0;  bit e0;  logic [31:0] d0;
    bit v1;  bit e1;  logic [31:0] d1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m1_lock;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load;
  logic [31:0] mem [0:1023];
  int          n_pass = 0;
  int          n_tot  = 0;
  vec_t        vq[$];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (1024),
    .MAX_WAIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .m1_lock_i   (m1_lock),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEAD_BEEF;
    return P + 32'(i);
  endfunction

  // Expected contents after all table writes: burst to 0..3, m0 write to 7.
  function automatic logic [31:0] final_val(input int i);
    if (i < 4)  return B + 32'(i);
    if (i == 7) return 32'h1234_5678;
    return init_val(i);
  endfunction

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (mem_write) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    m0_if.req = v.m0r; m0_if.we = v.m0w; m0_if.addr = v.m0a; m0_if.wdata = v.m0d;
    m1_if.req = v.m1r; m1_if.we = v.m1w; m1_if.addr = v.m1a; m1_if.wdata = v.m1d;
    m1_lock   = v.m1l;
  endtask

  task automatic idle();
    vec_t v;
    v = '{N,N,0,0, N,N,0,0,N, N,N,N,N,0, N,N,0, N,N,0};
    drive(v);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst m0_rvalid", 32'(m0_if.rvalid), 0);
    chk("rst m1_rvalid", 32'(m1_if.rvalid), 0);
    chk("rst m0_err",    32'(m0_if.err), 0);
    chk("rst m1_err",    32'(m1_if.err), 0);
    chk("rst m0_rdata",  m0_if.rdata, 0);
    chk("rst m1_rdata",  m1_if.rdata, 0);
    load  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //          m0: r w addr data       m1: r w addr data lock  exp: g0 g1 rd wr addr  v0 e0 d0  v1 e1 d1
    vq.push_back('{Y,N,5,0,            N,N,0,0,N,              Y,N,Y,N,5,     N,N,0,            N,N,0});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,N,32'hDEADBEEF, N,N,0});
    vq.push_back('{Y,Y,7,32'h12345678, N,N,0,0,N,              Y,N,N,Y,7,     N,N,32'hDEADBEEF, N,N,0});
    vq.push_back('{Y,N,7,0,            N,N,0,0,N,              Y,N,Y,N,7,     N,N,32'hDEADBEEF, N,N,0});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,N,32'h12345678, N,N,0});
    vq.push_back('{Y,N,1,0,            Y,N,2,0,N,              Y,N,Y,N,1,     N,N,32'h12345678, N,N,0});
    for (int k = 0; k < 3; k++)
      vq.push_back('{Y,N,1,0,          Y,N,2,0,N,              Y,N,Y,N,1,     Y,N,P+1,          N,N,0});
    vq.push_back('{Y,N,1,0,            Y,N,2,0,N,              N,Y,Y,N,2,     Y,N,P+1,          N,N,0});
    vq.push_back('{Y,N,1,0,            Y,N,2,0,N,              Y,N,Y,N,1,     N,N,P+1,          Y,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,N,P+1,          N,N,P+2});
    vq.push_back('{Y,N,1,0,            Y,Y,3,32'hCAFE0003,N,   Y,N,Y,N,1,     N,N,P+1,          N,N,P+2});
    for (int k = 0; k < 3; k++)
      vq.push_back('{Y,N,1,0,          Y,Y,3,32'hCAFE0003,N,   Y,N,Y,N,1,     Y,N,P+1,          N,N,P+2});
    vq.push_back('{Y,N,1,0,            Y,Y,3,32'hCAFE0003,N,   N,Y,N,Y,3,     Y,N,P+1,          N,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     N,N,P+1,          N,N,P+2});
    vq.push_back('{N,N,0,0,            Y,Y,0,B,Y,              N,Y,N,Y,0,     N,N,P+1,          N,N,P+2});
    for (int k = 1; k < 4; k++)
      vq.push_back('{Y,N,1,0,          Y,Y,32'(k),B+32'(k),Y,  N,Y,N,Y,32'(k), N,N,P+1,         N,N,P+2});
    vq.push_back('{Y,N,1,0,            N,N,0,0,N,              N,N,N,N,0,     N,N,P+1,          N,N,P+2});
    vq.push_back('{Y,N,1,0,            N,N,0,0,N,              Y,N,Y,N,1,     N,N,P+1,          N,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,N,B+1,          N,N,P+2});
    vq.push_back('{Y,N,0,0,            N,N,0,0,N,              Y,N,Y,N,0,     N,N,B+1,          N,N,P+2});
    vq.push_back('{Y,N,2,0,            N,N,0,0,N,              Y,N,Y,N,2,     Y,N,B,            N,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,N,B+2,          N,N,P+2});
    vq.push_back('{Y,Y,1024,32'hFFFFFFFF, N,N,0,0,N,           Y,N,N,N,1024,  N,N,B+2,          N,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     Y,Y,0,            N,N,P+2});
    vq.push_back('{N,N,0,0,            Y,N,2000,0,N,           N,Y,N,N,2000,  N,N,0,            N,N,P+2});
    vq.push_back('{N,N,0,0,            N,N,0,0,N,              N,N,N,N,0,     N,N,0,            Y,Y,0});

    foreach (vq[k]) begin
      drive(vq[k]);
      #3;
      chk($sformatf("row%0d m0_gnt", k),    32'(m0_if.gnt),    32'(vq[k].g0));
      chk($sformatf("row%0d m1_gnt", k),    32'(m1_if.gnt),    32'(vq[k].g1));
      chk($sformatf("row%0d memRead", k),   32'(mem_read),     32'(vq[k].rd));
      chk($sformatf("row%0d memWrite", k),  32'(mem_write),    32'(vq[k].wr));
      chk($sformatf("row%0d address", k),   mem_addr,          vq[k].ad);
      chk($sformatf("row%0d m0_rvalid", k), 32'(m0_if.rvalid), 32'(vq[k].v0));
      chk($sformatf("row%0d m0_err", k),    32'(m0_if.err),    32'(vq[k].e0));
      chk($sformatf("row%0d m0_rdata", k),  m0_if.rdata,       vq[k].d0);
      chk($sformatf("row%0d m1_rvalid", k), 32'(m1_if.rvalid), 32'(vq[k].v1));
      chk($sformatf("row%0d m1_err", k),    32'(m1_if.err),    32'(vq[k].e1));
      chk($sformatf("row%0d m1_rdata", k),  m1_if.rdata,       vq[k].d1);
      @(posedge clk);
      #1;
    end

    // Full readback: the rejected write must not have aliased onto any word.
    for (int i = 0; i < 1024; i++) begin
      m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'(i); m0_if.wdata = '0;
      @(posedge clk);
      #1;
      chk($sformatf("readback[%0d]", i), m0_if.rdata, final_val(i));
    end
    idle();
    @(posedge clk);
    #1;

    // Async reset in the middle of a locked m1 burst with a read in flight.
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 5; m1_lock = 1'b1;
    @(posedge clk);
    #1;
    chk("own1 m1_rdata", m1_if.rdata, 32'hDEAD_BEEF);
    m1_if.addr = 6;
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 1;
    #2;
    chk("own1 m1_gnt", 32'(m1_if.gnt), 1);
    chk("own1 m0_gnt", 32'(m0_if.gnt), 0);
    rst_n = 1'b0;
    #1;
    chk("arst m0_gnt",    32'(m0_if.gnt), 0);
    chk("arst m1_gnt",    32'(m1_if.gnt), 0);
    chk("arst memRead",   32'(mem_read), 0);
    chk("arst address",   mem_addr, 0);
    chk("arst m1_rvalid", 32'(m1_if.rvalid), 0);
    chk("arst m1_rdata",  m1_if.rdata, 0);
    @(posedge clk);
    #1;
    chk("arst hold m1_rvalid", 32'(m1_if.rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst m0_gnt", 32'(m0_if.gnt), 1);
    chk("post-rst m1_gnt", 32'(m1_if.gnt), 0);
    @(posedge clk);
    #1;
    chk("post-rst m1_rvalid", 32'(m1_if.rvalid), 0);
    chk("post-rst m0_rvalid", 32'(m0_if.rvalid), 1);
    chk("post-rst m0_rdata",  m0_if.rdata, B + 1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU load/store port (m0) and the program/data loader port (m1). Each cycle it picks at most one requester and drives the memory's memRead/memWrite/address/writeData strobes combinationally. It returns registered read data one cycle later. m0 has fixed priority, with three additions: a starvation counter that guarantees m1 forward progress, a lock for uninterrupted m1 bursts, and out-of-range address rejection. It sits between the processor datapath and the data memory.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- DEPTH, 1024, number of memory words; word address valid range is 0..DEPTH-1
- MAX_WAIT, 4, consecutive cycles m1 may be denied before a forced grant (1..15)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_req  in  1  request, N in {0,1}; held until granted
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  word address
- mN_wdata  in  DATA_W  write data
- m1_lock  in  1  m1 keeps ownership while req and lock are both high
- mN_gnt  out  1  combinational; access is performed this cycle
- mN_rvalid  out  1  registered; read data valid (one cycle after read grant)
- mN_rdata  out  DATA_W  registered read data
- mN_err  out  1  registered; pulses with rvalid timing for a rejected access
- memRead, memWrite  out  1  to memory
- address  out  ADDR_W  to memory
- writeData  out  DATA_W  to memory
- readData  in  DATA_W  from memory (combinational read)

## Operation
- State machine, states IDLE, OWN1:
  - IDLE: grant m0 if m0_req. Otherwise grant m1 if m1_req.
  - Forced grant in IDLE: if m1_req and the wait counter equals MAX_WAIT, grant m1 even if m0_req is high.
  - IDLE -> OWN1: on an m1 grant with m1_lock=1.
  - OWN1: m1 granted every cycle that m1_req is high. m0 is stalled (m0_gnt=0).
  - OWN1 -> IDLE: when m1_req=0 or m1_lock=0 at a clock edge. The cycle with lock low still grants m1 if it is requesting.
- Wait counter (4 bits):
  - Increments each cycle m1_req=1 and m1_gnt=0, saturating at MAX_WAIT.
  - Clears on any m1 grant or when m1_req=0.
- Memory drive:
  - With a grant, address and writeData come from the winner.
  - memWrite = winner's we. memRead = ~winner's we.
  - With no grant, all memory outputs are 0.
- Range check:
  - An access with mN_addr >= DEPTH is still granted, but memRead and memWrite stay 0.
  - The next cycle pulses mN_err=1 and mN_rvalid=1, with mN_rdata=0.
  - A rejected write also produces that err/rvalid pulse.
- Read return:
  - On a granted in-range read, readData is captured into mN_rdata at the edge.
  - mN_rvalid pulses for exactly one cycle.
  - Writes produce no rvalid.
- mN_rdata holds its last value until the next read return for that port.

## Timing
- Reset: state IDLE, wait counter 0. All registered outputs are 0: mN_rvalid, mN_err, mN_rdata.
- Reset mid-burst: OWN1 is dropped immediately. A pending rvalid is discarded.
- Latency:
  - Grant is 0 cycles (same cycle as req).
  - Write is committed at the grant cycle's rising edge.
  - Read data is 1 cycle after the grant.
- Back-to-back grants to the same port are allowed every cycle; throughput is 1 access per cycle.
- Simultaneous m0_req and m1_req in IDLE with counter < MAX_WAIT: m0 wins and the counter increments.
- Forced grant: m1 wins for exactly one cycle. If m1_lock is low, the next cycle reverts to m0 priority.
- Masters must hold req, we, addr and wdata stable until gnt; they may change them the cycle after gnt.

## Structure
- Shared package dmem_pkg holds:
  - the port-index constants M0 and M1;
  - the state encoding, IDLE=1'b0 and OWN1=1'b1;
  - the default DEPTH.
- One sub-module, rr_wait_counter: the saturating starvation counter with its inc/clr/at_max interface.
- The state machine, mux and return registers live in dmem_arbiter.

## Test plan
- Reset then m0 read only: m0 reads addr 5 (holding 32'hDEADBEEF) -> m0_gnt=1 at once, memRead=1, address=5; next cycle m0_rvalid=1, m0_rdata=32'hDEADBEEF.
- Contention: both req held, MAX_WAIT=4 -> m0 granted for 4 cycles, m1 granted on the 5th, then m0 resumes; counter returns to 0.
- Lock burst: m1 writes addresses 0..3 with m1_lock=1 while m0_req=1 -> 4 consecutive m1 grants, m0_gnt=0 throughout; m0 granted in the cycle after m1_req drops.
- Out of range: m0 writes to addr 1024 -> m0_gnt=1, memWrite=0; next cycle m0_err=1, m0_rvalid=1; a readback of every address shows no memory change.
- Write-then-read, same port: write 32'h12345678 to addr 7, then read addr 7 in the next cycle -> rdata 32'h12345678 one cycle later.
- Async reset asserted during OWN1 with a read in flight -> all outputs 0 immediately, no rvalid after release, m0 granted first after release.
